crypto_in_arb: RTL and testbench

Packet-granular round-robin arbiter that shares the single crypto datapath between two NetFPGA-style packet streams (e.g. host-bound and wire-bound traffic). Each input is buffered in a small fall-through FIFO. A state machine grants one input at a time and forwards that input's whole packet, from its module headers through EOP, to the crypto block with no interleaving. It also keeps per-input forwarded-packet counters for debug.

---
 rtl/crypto_in_arb_pkg.sv | 13 +
 rtl/crypto_in_arb_if.sv | 15 +
 rtl/fallthrough_small_fifo.sv | 56 +++++
 rtl/crypto_in_arb.sv | 149 ++++++++++++++
 tb/tb_crypto_in_arb.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crypto_in_arb_pkg.sv
// Shared types and constants for the crypto input arbiter.
package crypto_in_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } arb_state_t;

    // ctrl value carried by plain data words; anything else is a header or EOP
    localparam int unsigned CTRL_DATA_WORD = 0;

endpackage

// File: rtl/crypto_in_arb_if.sv
// NetFPGA-style data/ctrl/wr/rdy stream; master drives the word, slave drives rdy.
interface crypto_in_arb_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) ();

    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, output ctrl, output wr, input rdy);
    modport slave  (input data, input ctrl, input wr, output rdy);

endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small fall-through FIFO: the head word is presented on o_dout whenever o_empty is low.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_nearly_full,
    output logic             o_empty
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          r_mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
    logic [MAX_DEPTH_BITS:0]   r_count;
    logic                      w_full;
    logic                      w_do_wr;
    logic                      w_do_rd;

    assign w_full        = (r_count == (MAX_DEPTH_BITS+1)'(DEPTH));
    assign o_nearly_full = (r_count >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
    assign o_empty       = (r_count == '0);
    assign o_dout        = r_mem[r_rd_ptr];

    assign w_do_wr = i_wr_en && !w_full;
    assign w_do_rd = i_rd_en && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/crypto_in_arb.sv
// Packet-granular round-robin arbiter sharing one crypto datapath between two
// buffered packet streams, with per-input forwarded-packet counters.
module crypto_in_arb
    import crypto_in_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH_BITS = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    crypto_in_arb_if.slave         in_0,
    crypto_in_arb_if.slave         in_1,
    crypto_in_arb_if.master        out,
    output logic                   grant,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   pkt_cnt_0,
    output logic [CNT_WIDTH-1:0]   pkt_cnt_1
);

    localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;

    arb_state_t              r_state;
    arb_state_t              w_nxt_state;
    logic                    r_grant;
    logic                    w_nxt_grant;
    logic                    r_rr_next;
    logic [WORD_W-1:0]       w_head_0;
    logic [WORD_W-1:0]       w_head_1;
    logic [WORD_W-1:0]       w_head;
    logic                    w_empty_0;
    logic                    w_empty_1;
    logic                    w_nf_0;
    logic                    w_nf_1;
    logic                    w_gnt_empty;
    logic                    w_is_data;
    logic                    w_rd;
    logic                    w_rd_0;
    logic                    w_rd_1;
    logic                    w_eop;
    logic                    r_out_wr;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [CTRL_WIDTH-1:0]   r_out_ctrl;
    logic [CNT_WIDTH-1:0]    r_pkt_cnt_0;
    logic [CNT_WIDTH-1:0]    r_pkt_cnt_1;

    fallthrough_small_fifo #(
        .WIDTH          (WORD_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo_0 (
        .clk           (clk),
        .rst_n         (reset),
        .i_din         ({in_0.ctrl, in_0.data}),
        .i_wr_en       (in_0.wr),
        .i_rd_en       (w_rd_0),
        .o_dout        (w_head_0),
        .o_nearly_full (w_nf_0),
        .o_empty       (w_empty_0)
    );

    fallthrough_small_fifo #(
        .WIDTH          (WORD_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo_1 (
        .clk           (clk),
        .rst_n         (reset),
        .i_din         ({in_1.ctrl, in_1.data}),
        .i_wr_en       (in_1.wr),
        .i_rd_en       (w_rd_1),
        .o_dout        (w_head_1),
        .o_nearly_full (w_nf_1),
        .o_empty       (w_empty_1)
    );

    assign in_0.rdy = !w_nf_0;
    assign in_1.rdy = !w_nf_1;

    assign w_head      = r_grant ? w_head_1 : w_head_0;
    assign w_gnt_empty = r_grant ? w_empty_1 : w_empty_0;
    assign w_is_data   = (w_head[WORD_W-1 -: CTRL_WIDTH] == CTRL_WIDTH'(CTRL_DATA_WORD));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_grant <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_grant <= w_nxt_grant;
        end
    end

    // Preferred input is r_rr_next; the other input is granted only if it alone has data.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_grant = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (!(r_rr_next ? w_empty_1 : w_empty_0)) begin
                    w_nxt_grant = r_rr_next;
                    w_nxt_state = ST_HDR;
                end else if (!(r_rr_next ? w_empty_0 : w_empty_1)) begin
                    w_nxt_grant = !r_rr_next;
                    w_nxt_state = ST_HDR;
                end
            end
            ST_HDR:  if (w_rd && w_is_data) w_nxt_state = ST_BODY;
            ST_BODY: if (w_eop) w_nxt_state = ST_IDLE;
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd   = (r_state != ST_IDLE) && !w_gnt_empty && out.rdy;
        w_eop  = w_rd && (r_state == ST_BODY) && !w_is_data;
        w_rd_0 = w_rd && !r_grant;
        w_rd_1 = w_rd && r_grant;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_wr    <= 1'b0;
            r_out_data  <= '0;
            r_out_ctrl  <= '0;
            r_rr_next   <= 1'b0;
            r_pkt_cnt_0 <= '0;
            r_pkt_cnt_1 <= '0;
        end else begin
            r_out_wr <= w_rd;
            if (w_rd) begin
                {r_out_ctrl, r_out_data} <= w_head;
            end
            if (w_eop) begin
                r_rr_next <= !r_grant;
                if (r_grant) r_pkt_cnt_1 <= r_pkt_cnt_1 + 1'b1;
                else         r_pkt_cnt_0 <= r_pkt_cnt_0 + 1'b1;
            end
        end
    end

    assign out.wr    = r_out_wr;
    assign out.data  = r_out_data;
    assign out.ctrl  = r_out_ctrl;
    assign grant     = r_grant;
    assign busy      = (r_state != ST_IDLE);
    assign pkt_cnt_0 = r_pkt_cnt_0;
    assign pkt_cnt_1 = r_pkt_cnt_1;

endmodule

// File: tb/tb_crypto_in_arb.sv
// Scoreboard bench for crypto_in_arb: expected words queued at drive time, popped as out_wr words arrive.
module tb_crypto_in_arb;

    localparam int DW = 64;
    localparam int CW = 8;
    typedef logic [CW+DW-1:0] word_t;
    typedef word_t pkt_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        grant, busy, w_grant, w_busy;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  wcnt0, wcnt1;
    int          checks = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    word_t       exp_q[$];
    word_t       obs_q[$];
    int unsigned obs_cyc[$];
    int          rdy_viol = 0;
    logic        prev_rdy = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crypto_in_arb_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) if_in0 (), if_in1 (), if_out ();
    crypto_in_arb_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) if_w0 (), if_w1 (), if_wo ();

    crypto_in_arb #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .FIFO_DEPTH_BITS(2), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_0(if_in0), .in_1(if_in1), .out(if_out),
        .grant(grant), .busy(busy), .pkt_cnt_0(cnt0), .pkt_cnt_1(cnt1));

    // narrow-counter instance so wraparound is reachable in a short run
    crypto_in_arb #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .FIFO_DEPTH_BITS(2), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .reset(reset), .in_0(if_w0), .in_1(if_w1), .out(if_wo),
        .grant(w_grant), .busy(w_busy), .pkt_cnt_0(wcnt0), .pkt_cnt_1(wcnt1));

    always @(negedge clk) begin
        if (if_out.wr) begin
            obs_q.push_back({if_out.ctrl, if_out.data});
            obs_cyc.push_back(cyc);
            if (!prev_rdy) rdy_viol++;
        end
        prev_rdy = if_out.rdy;
    end

    function automatic pkt_t mk_pkt(input int port, input int id, input int nhdr, input int ndata);
        pkt_t p;
        int n = nhdr + ndata + 1;
        for (int i = 0; i < n; i++) begin
            logic [CW-1:0] c;
            c = (i < nhdr) ? 8'hFF : ((i == n - 1) ? 8'h40 : 8'h00);
            p.push_back({c, 8'(port), 8'(id), 16'(i), 32'($urandom())});
        end
        return p;
    endfunction

    function automatic logic port_rdy(input int port);
        case (port)
            0:       return if_in0.rdy;
            1:       return if_in1.rdy;
            default: return if_w1.rdy;
        endcase
    endfunction

    task automatic drive(input int port, input logic wr, input word_t w);
        case (port)
            0:       begin if_in0.wr = wr; {if_in0.ctrl, if_in0.data} = w; end
            1:       begin if_in1.wr = wr; {if_in1.ctrl, if_in1.data} = w; end
            default: begin if_w1.wr = wr; {if_w1.ctrl, if_w1.data} = w; end
        endcase
    endtask

    task automatic put_word(input int port, input word_t w);
        int unsigned guard = 0;
        while (!port_rdy(port) && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 400) begin
            checks++; fails++;
            $display("FAIL put_word_p%0d in_rdy got 0 want 1 (timeout)", port);
            return;
        end
        drive(port, 1'b1, w);
        @(posedge clk); #1;
        drive(port, 1'b0, w);
    endtask

    task automatic send_pkt(input int port, input pkt_t p);
        foreach (p[i]) put_word(port, p[i]);
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int i = 0; i < budget && obs_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        rdy_viol = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if_out.wr !== 1'b0) begin fails++; $display("FAIL reset_out_wr got %b want 0", if_out.wr); end
        checks++; if (if_out.data !== '0) begin fails++; $display("FAIL reset_out_data got %h want 0", if_out.data); end
        checks++; if (if_out.ctrl !== '0) begin fails++; $display("FAIL reset_out_ctrl got %h want 0", if_out.ctrl); end
        checks++; if (grant !== 1'b0) begin fails++; $display("FAIL reset_grant got %b want 0", grant); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (cnt0 !== 16'd0) begin fails++; $display("FAIL reset_cnt0 got %0d want 0", cnt0); end
        checks++; if (cnt1 !== 16'd0) begin fails++; $display("FAIL reset_cnt1 got %0d want 0", cnt1); end
        checks++; if (if_in0.rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy_0 got %b want 1", if_in0.rdy); end
        checks++; if (if_in1.rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy_1 got %b want 1", if_in1.rdy); end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        pkt_t p;
        word_t e, o;
        do_reset();
        if_out.rdy = 1'b1;
        p = mk_pkt(0, 1, 1, 6);
        foreach (p[i]) exp_q.push_back(p[i]);
        send_pkt(0, p);
        wait_out(8, 100);
        checks++; if (obs_q.size() != 8) begin fails++; $display("FAIL single_count got %0d want 8", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin fails++; $display("FAIL single_word got %h want %h", o, e); end
        end
        checks++; if (cnt0 !== 16'd1) begin fails++; $display("FAIL single_cnt0 got %0d want 1", cnt0); end
        checks++; if (cnt1 !== 16'd0) begin fails++; $display("FAIL single_cnt1 got %0d want 0", cnt1); end
        checks++; if (grant !== 1'b0) begin fails++; $display("FAIL single_grant got %b want 0", grant); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b want 0", busy); end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_simultaneous();
        pkt_t a, b;
        word_t e, o;
        int unsigned gap;
        do_reset();
        a = mk_pkt(0, 2, 1, 2);
        b = mk_pkt(1, 3, 2, 2);
        foreach (a[i]) exp_q.push_back(a[i]);
        foreach (b[i]) exp_q.push_back(b[i]);
        fork
            send_pkt(0, a);
            send_pkt(1, b);
        join
        wait_out(9, 100);
        checks++; if (obs_q.size() != 9) begin fails++; $display("FAIL simul_count got %0d want 9", obs_q.size()); end
        if (obs_cyc.size() >= 5) begin
            gap = obs_cyc[4] - obs_cyc[3];
            checks++; if (gap != 2) begin fails++; $display("FAIL simul_idle_gap got %0d want 2", gap); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin fails++; $display("FAIL simul_word got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_alternate();
        pkt_t p0[3], p1[3];
        word_t e, o;
        int total = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            p0[k] = mk_pkt(0, 20 + k, k % 2, 2 + k);
            p1[k] = mk_pkt(1, 30 + k, 1, 3 - k);
        end
        for (int k = 0; k < 3; k++) begin
            foreach (p0[k][i]) exp_q.push_back(p0[k][i]);
            foreach (p1[k][i]) exp_q.push_back(p1[k][i]);
        end
        total = exp_q.size();
        fork
            for (int k = 0; k < 3; k++) send_pkt(0, p0[k]);
            for (int k = 0; k < 3; k++) send_pkt(1, p1[k]);
        join
        wait_out(total, 300);
        checks++; if (obs_q.size() != total) begin fails++; $display("FAIL alt_count got %0d want %0d", obs_q.size(), total); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin fails++; $display("FAIL alt_word got %h want %h", o, e); end
        end
        checks++; if (cnt0 !== 16'd3) begin fails++; $display("FAIL alt_cnt0 got %0d want 3", cnt0); end
        checks++; if (cnt1 !== 16'd3) begin fails++; $display("FAIL alt_cnt1 got %0d want 3", cnt1); end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_rdy_toggle();
        pkt_t p;
        word_t e, o;
        rdy_viol = 0;
        p = mk_pkt(1, 7, 2, 5);
        foreach (p[i]) exp_q.push_back(p[i]);
        fork
            send_pkt(1, p);
            begin
                for (int i = 0; i < 300 && obs_q.size() < 8; i++) begin
                    if_out.rdy = i[0];
                    @(posedge clk); #1;
                end
                if_out.rdy = 1'b1;
            end
        join
        wait_out(8, 50);
        checks++; if (obs_q.size() != 8) begin fails++; $display("FAIL toggle_count got %0d want 8", obs_q.size()); end
        checks++; if (rdy_viol != 0) begin fails++; $display("FAIL toggle_wr_after_rdy_low got %0d want 0", rdy_viol); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin fails++; $display("FAIL toggle_word got %h want %h", o, e); end
        end
        checks++; if (cnt1 !== 16'd4) begin fails++; $display("FAIL toggle_cnt1 got %0d want 4", cnt1); end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_stall();
        pkt_t a, b;
        word_t e, o;
        do_reset();
        a = mk_pkt(0, 8, 1, 6);
        b = mk_pkt(1, 9, 1, 3);
        foreach (a[i]) exp_q.push_back(a[i]);
        foreach (b[i]) exp_q.push_back(b[i]);
        fork
            begin
                for (int i = 0; i < 3; i++) put_word(0, a[i]);
                repeat (10) begin @(posedge clk); #1; end
                for (int i = 3; i < a.size(); i++) put_word(0, a[i]);
            end
            begin
                repeat (3) begin @(posedge clk); #1; end
                send_pkt(1, b);
            end
        join
        wait_out(13, 100);
        checks++; if (obs_q.size() != 13) begin fails++; $display("FAIL stall_count got %0d want 13", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin fails++; $display("FAIL stall_word got %h want %h", o, e); end
        end
        checks++; if (cnt0 !== 16'd1) begin fails++; $display("FAIL stall_cnt0 got %0d want 1", cnt0); end
        checks++; if (cnt1 !== 16'd1) begin fails++; $display("FAIL stall_cnt1 got %0d want 1", cnt1); end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset_mid();
        pkt_t p, q;
        word_t e, o;
        p = mk_pkt(0, 11, 1, 8);
        if_out.rdy = 1'b0;
        for (int i = 0; i < 3; i++) put_word(0, p[i]);
        if_out.rdy = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_pre_busy got %b want 1", busy); end
        checks++; if (if_out.wr !== 1'b1) begin fails++; $display("FAIL midrst_pre_out_wr got %b want 1", if_out.wr); end
        #2 reset = 1'b0;
        #1;
        checks++; if (if_out.wr !== 1'b0) begin fails++; $display("FAIL midrst_out_wr got %b want 0", if_out.wr); end
        checks++; if (if_out.data !== '0) begin fails++; $display("FAIL midrst_out_data got %h want 0", if_out.data); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (cnt0 !== 16'd0) begin fails++; $display("FAIL midrst_cnt0 got %0d want 0", cnt0); end
        checks++; if (cnt1 !== 16'd0) begin fails++; $display("FAIL midrst_cnt1 got %0d want 0", cnt1); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (if_in0.rdy !== 1'b1) begin fails++; $display("FAIL midrst_in_rdy_0 got %b want 1", if_in0.rdy); end
        checks++; if (if_in1.rdy !== 1'b1) begin fails++; $display("FAIL midrst_in_rdy_1 got %b want 1", if_in1.rdy); end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        q = mk_pkt(0, 12, 2, 3);
        foreach (q[i]) exp_q.push_back(q[i]);
        send_pkt(0, q);
        wait_out(6, 100);
        checks++; if (obs_q.size() != 6) begin fails++; $display("FAIL midrst_next_count got %0d want 6", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin fails++; $display("FAIL midrst_next_word got %h want %h", o, e); end
        end
        checks++; if (cnt0 !== 16'd1) begin fails++; $display("FAIL midrst_next_cnt0 got %0d want 1", cnt0); end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 15; k++) send_pkt(2, mk_pkt(1, k, 0, 1));
        repeat (20) begin @(posedge clk); #1; end
        checks++; if (wcnt1 !== 4'd15) begin fails++; $display("FAIL wrap_pre_cnt1 got %0d want 15", wcnt1); end
        checks++; if (wcnt0 !== 4'd0) begin fails++; $display("FAIL wrap_cnt0 got %0d want 0", wcnt0); end
        send_pkt(2, mk_pkt(1, 15, 0, 1));
        repeat (20) begin @(posedge clk); #1; end
        checks++; if (wcnt1 !== 4'd0) begin fails++; $display("FAIL wrap_cnt1 got %0d want 0", wcnt1); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if_in0.wr = 1'b0; if_in0.data = '0; if_in0.ctrl = '0;
        if_in1.wr = 1'b0; if_in1.data = '0; if_in1.ctrl = '0;
        if_w0.wr  = 1'b0; if_w0.data  = '0; if_w0.ctrl  = '0;
        if_w1.wr  = 1'b0; if_w1.data  = '0; if_w1.ctrl  = '0;
        if_out.rdy = 1'b1;
        if_wo.rdy  = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_alternate();
        test_rdy_toggle();
        test_stall();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
